// File: rtl/pop_btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pop_btn_pkg
// Description : Shared constants and state encoding for the POP front-panel
//               button conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package pop_btn_pkg;

    localparam int BTN_PI2_PLUS       = 0;
    localparam int BTN_PI2_MINUS      = 1;
    localparam int BTN_FREEP_PLUS     = 2;
    localparam int BTN_FREEP_MINUS    = 3;
    localparam int BTN_LOAD_DEFAULTS  = 4;

    localparam int NUM_BTN_DEFAULT         = 5;
    localparam int CNT_WIDTH_DEFAULT       = 21;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 25000;
    localparam int REPEAT_DELAY_DEFAULT    = 1250000;
    localparam int REPEAT_PERIOD_DEFAULT   = 250000;
    localparam logic [NUM_BTN_DEFAULT-1:0] REPEAT_MASK_DEFAULT = 5'b01111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RPT     = 2'd2,
        ST_LATCHED = 2'd3
    } rpt_state_t;

endpackage
`default_nettype wire

// File: rtl/pop_btn_channel.sv
`default_nettype none
// ============================================================================
// Module      : pop_btn_channel
// Description : One button: 2-FF synchroniser, debounce and auto-repeat FSM
//               sharing a single saturating timer.
// Revision    : 1.0 - initial release
// ============================================================================
module pop_btn_channel
    import pop_btn_pkg::*;
#(
    parameter logic ACTIVE_LOW      = 1'b1,
    parameter int   CNT_WIDTH       = CNT_WIDTH_DEFAULT,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int   REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int   REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
    parameter logic REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    input  logic i_inhibit,
    output logic o_pulse,
    output logic o_level
);

    localparam logic [CNT_WIDTH-1:0] c_dbnc_last  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_delay_last = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] c_per_last   = CNT_WIDTH'(REPEAT_PERIOD - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_level;
    logic                 r_pulse;
    logic                 r_dbnc;
    logic [CNT_WIDTH-1:0] r_timer;
    rpt_state_t           r_state;

    logic                 w_s;
    logic                 w_differ;
    logic                 w_settled;
    logic [CNT_WIDTH-1:0] w_dbnc_cnt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign w_s        = r_sync2 ^ ACTIVE_LOW;
    assign w_differ   = (w_s != r_level);
    // r_dbnc marks the timer as holding a debounce count rather than repeat time
    assign w_settled  = ~w_differ & ~r_dbnc;
    assign w_dbnc_cnt = r_dbnc ? r_timer : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_dbnc  <= 1'b0;
            r_timer <= '0;
            r_state <= ST_IDLE;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;

            if (w_differ) begin
                if (w_dbnc_cnt >= c_dbnc_last) begin
                    r_level <= w_s;
                    r_timer <= '0;
                    r_dbnc  <= 1'b0;
                end else begin
                    r_timer <= sat_inc(w_dbnc_cnt);
                    r_dbnc  <= 1'b1;
                end
            end else if (r_dbnc) begin
                r_timer <= '0;
                r_dbnc  <= 1'b0;
            end

            // Repeat pulses only fire while debounce is idle, so a release in
            // progress swallows any repeat that falls due during it.
            case (r_state)
                ST_IDLE: begin
                    if (r_level) begin
                        r_pulse <= ~i_inhibit;
                        r_state <= REPEAT_EN ? ST_HOLD : ST_LATCHED;
                    end
                end
                ST_HOLD: begin
                    if (!r_level) begin
                        r_state <= ST_IDLE;
                    end else if (w_settled) begin
                        if (r_timer >= c_delay_last) begin
                            r_pulse <= ~i_inhibit;
                            r_timer <= '0;
                            r_state <= ST_RPT;
                        end else begin
                            r_timer <= sat_inc(r_timer);
                        end
                    end
                end
                ST_RPT: begin
                    if (!r_level) begin
                        r_state <= ST_IDLE;
                    end else if (w_settled) begin
                        if (r_timer >= c_per_last) begin
                            r_pulse <= ~i_inhibit;
                            r_timer <= '0;
                        end else begin
                            r_timer <= sat_inc(r_timer);
                        end
                    end
                end
                ST_LATCHED: begin
                    if (!r_level) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_pulse = r_pulse;
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/pop_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pop_button_conditioner
// Description : Front-panel button conditioner for the POP timing sequencer:
//               per-channel debounce/auto-repeat plus plus/minus pair masking.
// Revision    : 1.0 - initial release
// ============================================================================
module pop_button_conditioner
    import pop_btn_pkg::*;
#(
    parameter int   NUM_BTN         = NUM_BTN_DEFAULT,
    parameter logic ACTIVE_LOW      = 1'b1,
    parameter int   CNT_WIDTH       = CNT_WIDTH_DEFAULT,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int   REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int   REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK = NUM_BTN'(REPEAT_MASK_DEFAULT)
) (
    input  logic               clk_2M5,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               any_pressed
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_pulse;
    logic [NUM_BTN-1:0] w_inhibit;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        // Adjust buttons come in plus/minus pairs (0/1, 2/3); a pressed partner
        // blocks this channel's pulses so opposing steps never cancel mid-run.
        if ((i < BTN_LOAD_DEFAULTS) && ((i ^ 1) < NUM_BTN)) begin : g_paired
            assign w_inhibit[i] = w_level[i ^ 1];
        end else begin : g_unpaired
            assign w_inhibit[i] = 1'b0;
        end

        pop_btn_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .CNT_WIDTH       (CNT_WIDTH),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_chan (
            .clk       (clk_2M5),
            .rst       (reset),
            .i_btn_raw (btn_raw[i]),
            .i_inhibit (w_inhibit[i]),
            .o_pulse   (w_pulse[i]),
            .o_level   (w_level[i])
        );
    end

    assign btn_pulse   = w_pulse;
    assign btn_level   = w_level;
    assign any_pressed = |w_level;

endmodule
`default_nettype wire

// File: tb/tb_pop_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_pop_button_conditioner
// Description : Self-checking bench: vector table, directed corner sequences
//               and random stimulus against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pop_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam logic [4:0] REL = 5'b11111;

    logic       clk_2M5 = 1'b0;
    logic       reset   = 1'b1;
    logic [4:0] btn_raw = REL;
    logic [4:0] btn_pulse;
    logic [4:0] btn_level;
    logic       any_pressed;

    always #200 clk_2M5 = ~clk_2M5;

    pop_button_conditioner #(
        .NUM_BTN         (5),
        .ACTIVE_LOW      (1'b1),
        .CNT_WIDTH       (21),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (5'b01111)
    ) dut (
        .clk_2M5     (clk_2M5),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_pulse   (btn_pulse),
        .btn_level   (btn_level),
        .any_pressed (any_pressed)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: raw samples reach the debouncer two edges late; a level
    // is accepted after D consecutive differing samples; pulses fall at fixed
    // offsets from the rising edge of the accepted level.
    logic [4:0] rmask = 5'b01111;
    logic [4:0] q_raw[$];
    logic [4:0] m_lvl   = '0;
    logic [4:0] m_pulse = '0;
    int         m_run[5];
    longint     m_rise[5];
    longint     edge_no = 0;
    int         pcnt[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic model_step(input logic rst, input logic [4:0] raw);
        logic [4:0] s;
        logic [4:0] prev;
        longint     age;
        bit         due;
        if (rst) begin
            q_raw.delete();
            q_raw.push_back(REL);
            q_raw.push_back(REL);
            m_lvl   = '0;
            m_pulse = '0;
            for (int b = 0; b < 5; b++) m_run[b] = 0;
        end else begin
            s = ~q_raw.pop_front();
            q_raw.push_back(raw);
            prev = m_lvl;
            for (int b = 0; b < 5; b++) begin
                age = edge_no - m_rise[b];
                due = prev[b] && (age == 1 ||
                      (rmask[b] && s[b] == prev[b] && age >= 1 + RD && (age - 1 - RD) % RP == 0));
                if (b < 4) begin
                    if (prev[b ^ 1]) due = 1'b0;
                end
                m_pulse[b] = due;
            end
            for (int b = 0; b < 5; b++) begin
                if (s[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D) begin
                        m_lvl[b] = s[b];
                        m_run[b] = 0;
                        if (s[b]) m_rise[b] = edge_no;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
        edge_no++;
    endtask

    task automatic tick();
        @(posedge clk_2M5);
        model_step(reset, btn_raw);
        #1;
        chk("btn_level", 64'(btn_level), 64'(m_lvl));
        chk("btn_pulse", 64'(btn_pulse), 64'(m_pulse));
        chk("any_pressed", 64'(any_pressed), 64'(|m_lvl));
        for (int b = 0; b < 5; b++) if (btn_pulse[b]) pcnt[b]++;
    endtask

    task automatic run_for(input logic [4:0] raw, input int n);
        btn_raw = raw;
        for (int k = 0; k < n; k++) tick();
    endtask

    // Edges from the first sampling edge until bit b pulses, or -1 on timeout.
    task automatic latency(input int b, output int found);
        found = -1;
        for (int k = 0; k < 40 && found < 0; k++) begin
            tick();
            if (btn_pulse[b]) found = k;
        end
    endtask

    typedef struct {
        logic [4:0]      raw;
        int              hold;
        logic [4:0]      exp_level;
        logic [4:0][7:0] exp_cnt;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] raw, input int hold, input logic [4:0] lvl,
                                input int c4, input int c3, input int c2, input int c1, input int c0);
        vec_t v;
        v.raw = raw; v.hold = hold; v.exp_level = lvl;
        v.exp_cnt = {8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
        return v;
    endfunction

    vec_t   vecs[$];
    longint ptimes[$];
    int     exp_rel[6] = '{0, 20, 28, 36, 44, 52};
    int     lat;
    int     lvl_hi;
    int     tgt[5];
    int     run[5];
    logic [4:0] cur;

    initial begin
        vecs.push_back(mk(REL,     100, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(5'b11110, 10, 5'b00001, 0, 0, 0, 0, 1));
        vecs.push_back(mk(REL,      20, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(5'b11101, 60, 5'b00010, 0, 0, 0, 6, 0));
        vecs.push_back(mk(REL,      20, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(5'b01111, 60, 5'b10000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(REL,      20, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(5'b11100, 60, 5'b00011, 0, 0, 0, 0, 0));
        vecs.push_back(mk(REL,      20, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(5'b01110, 30, 5'b10001, 1, 0, 0, 0, 2));
        vecs.push_back(mk(REL,      20, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(5'b10011, 30, 5'b01100, 0, 0, 0, 0, 0));
        vecs.push_back(mk(REL,      20, 5'b00000, 0, 0, 0, 0, 0));

        reset = 1'b1;
        run_for(REL, 3);
        chk("reset_level", 64'(btn_level), 64'd0);
        chk("reset_pulse", 64'(btn_pulse), 64'd0);
        chk("reset_any", 64'(any_pressed), 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            for (int b = 0; b < 5; b++) pcnt[b] = 0;
            run_for(vecs[i].raw, vecs[i].hold);
            for (int b = 0; b < 5; b++)
                chk($sformatf("vec%0d_pulses_bit%0d", i, b), 64'(pcnt[b]), 64'(vecs[i].exp_cnt[b]));
            chk($sformatf("vec%0d_level", i), 64'(btn_level), 64'(vecs[i].exp_level));
        end

        // Press-to-pulse latency on bit3
        btn_raw = 5'b10111;
        latency(3, lat);
        chk("latency_bit3", 64'(lat), 64'(D + 2));
        run_for(REL, 20);

        // Short glitches on bit2 must never be accepted
        lvl_hi = 0;
        for (int b = 0; b < 5; b++) pcnt[b] = 0;
        for (int g = 0; g < 10; g++) begin
            btn_raw = 5'b11011;
            for (int k = 0; k < 3; k++) begin tick(); if (btn_level[2]) lvl_hi++; end
            btn_raw = REL;
            for (int k = 0; k < 3; k++) begin tick(); if (btn_level[2]) lvl_hi++; end
        end
        chk("glitch_level_bit2", 64'(lvl_hi), 64'd0);
        chk("glitch_pulses_bit2", 64'(pcnt[2]), 64'd0);
        run_for(REL, 10);

        // Auto-repeat timing on bit1
        btn_raw = 5'b11101;
        ptimes.delete();
        for (int k = 0; k < 66; k++) begin
            tick();
            if (btn_pulse[1]) ptimes.push_back(edge_no);
        end
        chk("repeat_count_bit1", 64'(ptimes.size()), 64'd6);
        if (ptimes.size() == 6)
            for (int j = 0; j < 6; j++)
                chk($sformatf("repeat_time%0d_bit1", j), 64'(ptimes[j] - ptimes[0]), 64'(exp_rel[j]));
        run_for(REL, 20);

        // Reset while bit2 is auto-repeating, then a fresh full debounce
        run_for(5'b11011, 40);
        chk("pre_reset_level_bit2", 64'(btn_level[2]), 64'd1);
        reset = 1'b1;
        tick();
        chk("midrpt_reset_level", 64'(btn_level), 64'd0);
        chk("midrpt_reset_pulse", 64'(btn_pulse), 64'd0);
        chk("midrpt_reset_any", 64'(any_pressed), 64'd0);
        reset = 1'b0;
        latency(2, lat);
        chk("post_reset_latency_bit2", 64'(lat), 64'(D + 2));
        run_for(REL, 20);

        // Random stimulus; released stretches always outlast the debounce window
        cur = REL;
        for (int b = 0; b < 5; b++) begin
            tgt[b] = $urandom_range(D, 40);
            run[b] = 0;
        end
        for (int c = 0; c < 2500; c++) begin
            for (int b = 0; b < 5; b++) begin
                run[b]++;
                if (run[b] >= tgt[b]) begin
                    cur[b] = ~cur[b];
                    run[b] = 0;
                    if (cur[b] == 1'b0)
                        tgt[b] = ($urandom % 3 == 0) ? $urandom_range(1, D - 1) : $urandom_range(D, 70);
                    else
                        tgt[b] = $urandom_range(D, 40);
                end
            end
            btn_raw = cur;
            tick();
        end
        run_for(REL, 20);
        chk("final_idle_level", 64'(btn_level), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
